// File: rtl/serial_cmd_rx.sv
// serial_cmd_rx: UART receiver (8N1, LSB first) with a 4-byte command assembler.
//
// A command is addr[23:16], addr[15:8], addr[7:0], data. If too long a gap
// occurs between bytes, or a framing error occurs, the partial command is
// dropped. Neither case produces a write.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit period
//   TIMEOUT_BITS  inter-byte gap, in bit periods, that aborts a partial command
// Ports
//   clk        single clock for all logic
//   reset      asynchronous, active-low reset
//   RX         asynchronous UART line, idle high
//   rx_byte    last correctly received byte
//   rx_valid   one-cycle pulse when rx_byte updates
//   wr_addr    address of the last complete command
//   wr_data    data of the last complete command
//   wr_en      one-cycle pulse when wr_addr/wr_data update (same cycle as rx_valid)
//   frame_err  one-cycle pulse on a bad stop bit
//   busy       high whenever the receive FSM is not idle
module serial_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic [23:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GAP_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_meta_q, rx_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok, byte_bad;

  logic [1:0]       bcnt_q, bcnt_d, bcnt_base;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             timeout;
  logic [23:0]      shadow_q, shadow_d;
  logic [23:0]      wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             wr_en_d;

  logic [7:0]       rx_byte_q;
  logic             rx_valid_q, wr_en_q, frame_err_q, busy_q;

  // Receive FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_bad = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Command assembler. A timeout in the same cycle as a new byte makes that
  // byte the first of a fresh command.
  always_comb begin
    timeout   = (bcnt_q != 2'd0) && (gap_q == GAP_END);
    bcnt_base = timeout ? 2'd0 : bcnt_q;
    bcnt_d    = bcnt_base;
    shadow_d  = shadow_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    if (byte_bad) begin
      bcnt_d = 2'd0;
    end else if (byte_ok) begin
      unique case (bcnt_base)
        2'd0: shadow_d[23:16] = shift_q;
        2'd1: shadow_d[15:8]  = shift_q;
        2'd2: shadow_d[7:0]   = shift_q;
        default: begin
          wr_addr_d = shadow_q;
          wr_data_d = shift_q;
          wr_en_d   = 1'b1;
        end
      endcase
      bcnt_d = bcnt_base + 2'd1;
    end

    if (bcnt_q == 2'd0 || byte_ok) gap_d = '0;
    else if (gap_q != GAP_END)     gap_d = gap_q + GAP_W'(1);
    else                           gap_d = gap_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
      gap_q       <= '0;
      shadow_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      gap_q       <= gap_d;
      shadow_q    <= shadow_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      if (byte_ok) rx_byte_q <= shift_q;
      rx_valid_q  <= byte_ok;
      frame_err_q <= byte_bad;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_cmd_rx.sv
// tb_serial_cmd_rx: directed bench for serial_cmd_rx at 217 clocks per bit.
// A monitor counts rx_valid/wr_en/frame_err pulses and flags any pulse that
// is longer than one cycle, and any wr_en that occurs without rx_valid.
module tb_serial_cmd_rx;

  localparam int unsigned CPB = 217;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [23:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        frame_err;
  logic        busy;

  serial_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .RX       (RX),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int rv_cnt = 0;
  int we_cnt = 0;
  int fe_cnt = 0;
  int pulse_err = 0;
  logic [7:0] last_rx = '0;
  logic prev_rv = 1'b0, prev_we = 1'b0, prev_fe = 1'b0;

  int rv0, we0, fe0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rv_cnt++;
        last_rx = rx_byte;
      end
      if (wr_en) begin
        we_cnt++;
        if (!rx_valid) pulse_err++;
      end
      if (frame_err) fe_cnt++;
      if ((rx_valid && prev_rv) || (wr_en && prev_we) || (frame_err && prev_fe))
        pulse_err++;
    end
    prev_rv = rx_valid;
    prev_we = wr_en;
    prev_fe = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic snap();
    rv0 = rv_cnt;
    we0 = we_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    RX    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset rx_byte",   32'(rx_byte), 32'h0);
    check("reset wr_addr",   32'(wr_addr), 32'h0);
    check("reset wr_data",   32'(wr_data), 32'h0);
    check("reset pulses",    32'({rx_valid, wr_en, frame_err}), 32'h0);
    check("reset busy",      32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte: one rx_valid, no write.
    snap();
    send_byte(8'h55, 1'b1);
    idle_bits(1);
    check("single rx count", 32'(rv_cnt - rv0), 32'd1);
    check("single last_rx",  32'(last_rx), 32'h55);
    check("single rx_byte",  32'(rx_byte), 32'h55);
    check("single no wr_en", 32'(we_cnt - we0), 32'd0);
    check("single busy idle", 32'(busy), 32'h0);
    // Let the lone byte time out so it does not prefix the next command.
    idle_bits(22);

    // Full command.
    snap();
    send_byte(8'h01, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'hAB, 1'b1);
    idle_bits(1);
    check("cmd wr_en count", 32'(we_cnt - we0), 32'd1);
    check("cmd rx count",    32'(rv_cnt - rv0), 32'd4);
    check("cmd wr_addr",     32'(wr_addr), 32'h012345);
    check("cmd wr_data",     32'(wr_data), 32'hAB);

    // Glitch: 50 low cycles is shorter than half a bit.
    snap();
    RX = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch busy high", 32'(busy), 32'h1);
    repeat (10) @(negedge clk);
    RX = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch busy low",  32'(busy), 32'h0);
    check("glitch no rx",     32'(rv_cnt - rv0), 32'd0);
    check("glitch no fe",     32'(fe_cnt - fe0), 32'd0);

    // Framing error, held break, then a full command.
    snap();
    send_byte(8'h12, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b0);
    check("break busy",       32'(busy), 32'h1);
    idle_bits(1);
    check("frame fe count",   32'(fe_cnt - fe0), 32'd1);
    check("frame no rx",      32'(rv_cnt - rv0), 32'd0);
    check("frame busy low",   32'(busy), 32'h0);
    check("frame keeps addr", 32'(wr_addr), 32'h012345);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    idle_bits(1);
    check("frame wr_en count", 32'(we_cnt - we0), 32'd1);
    check("frame wr_addr",     32'(wr_addr), 32'hAABBCC);
    check("frame wr_data",     32'(wr_data), 32'hDD);
    check("frame fe total",    32'(fe_cnt - fe0), 32'd1);

    // Timeout drops a partial command.
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle_bits(25);
    check("timeout no wr_en", 32'(we_cnt - we0), 32'd0);
    check("timeout keeps addr", 32'(wr_addr), 32'hAABBCC);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    idle_bits(1);
    check("timeout wr_en count", 32'(we_cnt - we0), 32'd1);
    check("timeout wr_addr",     32'(wr_addr), 32'h334455);
    check("timeout wr_data",     32'(wr_data), 32'h66);

    // Reset during bit 4 of 0xF0.
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    RX = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("midbyte busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset busy",    32'(busy), 32'h0);
    check("midreset rx_byte", 32'(rx_byte), 32'h0);
    check("midreset wr_addr", 32'(wr_addr), 32'h0);
    check("midreset wr_data", 32'(wr_data), 32'h0);
    rst_n = 1'b1;
    idle_bits(5);
    check("midreset no rx",   32'(rv_cnt - rv0), 32'd0);
    check("midreset no fe",   32'(fe_cnt - fe0), 32'd0);
    send_byte(8'h7E, 1'b1);
    idle_bits(1);
    check("post reset rx count", 32'(rv_cnt - rv0), 32'd1);
    check("post reset rx_byte",  32'(rx_byte), 32'h7E);
    check("post reset no wr_en", 32'(we_cnt - we0), 32'd0);
    // Byte counter must have restarted at 0, so 0x7E is the first address byte.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle_bits(1);
    check("post reset wr_en", 32'(we_cnt - we0), 32'd1);
    check("post reset addr",  32'(wr_addr), 32'h7E0102);
    check("post reset data",  32'(wr_data), 32'h03);

    check("pulse width/align", 32'(pulse_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
